// File: rtl/wb_cmd_master_if.sv
// Command/response and Wishbone classic signal bundle for wb_cmd_master.
// The master modport is the block's own view; slave is the view of
// everything around it (command source, response sink and the bus slave).
interface wb_cmd_master_if;
    // command channel
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    // response channel
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_timeout_o;
    // Wishbone classic master
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    // status
    logic [7:0]  timeout_cnt_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        input  rsp_ready_i,
        output rsp_valid_o, rsp_dat_o, rsp_timeout_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        input  wbm_ack_i, wbm_dat_i,
        output timeout_cnt_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        output rsp_ready_i,
        input  rsp_valid_o, rsp_dat_o, rsp_timeout_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
        output wbm_ack_i, wbm_dat_i,
        input  timeout_cnt_o
    );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns single valid/ready commands into Wishbone classic
// cycles and returns one response per command. Three-state FSM
// (IDLE -> BUS -> RESP), every output registered.
// Optional bus-cycle timeout: define WBM_TIMEOUT_EN to build the wait
// counter, abort logic and saturating timeout counter; otherwise BUS waits
// for ack indefinitely and the timeout outputs are tied low.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    wb_cmd_master_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Elaboration-time guard on the timeout range (counter is 8 bits wide).
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("wb_cmd_master: TIMEOUT must be within 1..255");
    end

    state_t      r_state,     w_state_nxt;
    logic        r_cmd_ready, w_cmd_ready_nxt;
    logic        r_rsp_valid, w_rsp_valid_nxt;
    logic [31:0] r_rsp_dat,   w_rsp_dat_nxt;
    // one register drives both cyc and stb so they can never disagree
    logic        r_cyc,       w_cyc_nxt;
    logic        r_we,        w_we_nxt;
    logic [31:0] r_adr,       w_adr_nxt;
    logic [31:0] r_dat,       w_dat_nxt;
    logic [3:0]  r_sel,       w_sel_nxt;

`ifdef WBM_TIMEOUT_EN
    // Abort fires on the edge that closes the TIMEOUT-th BUS cycle without ack.
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    logic [7:0]  r_wait_cnt,    w_wait_cnt_nxt;
    logic        r_rsp_timeout, w_rsp_timeout_nxt;
    logic [7:0]  r_timeout_cnt, w_timeout_cnt_nxt;
`endif

    // State and output registers; reset drops cyc/stb asynchronously.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= '0;
            r_cyc         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_dat         <= '0;
            r_sel         <= '0;
`ifdef WBM_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_rsp_timeout <= 1'b0;
            r_timeout_cnt <= '0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_dat     <= w_rsp_dat_nxt;
            r_cyc         <= w_cyc_nxt;
            r_we          <= w_we_nxt;
            r_adr         <= w_adr_nxt;
            r_dat         <= w_dat_nxt;
            r_sel         <= w_sel_nxt;
`ifdef WBM_TIMEOUT_EN
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_timeout_cnt <= w_timeout_cnt_nxt;
`endif
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        w_state_nxt       = r_state;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_dat_nxt     = r_rsp_dat;
        w_cyc_nxt         = r_cyc;
        w_we_nxt          = r_we;
        w_adr_nxt         = r_adr;
        w_dat_nxt         = r_dat;
        w_sel_nxt         = r_sel;
`ifdef WBM_TIMEOUT_EN
        w_wait_cnt_nxt    = r_wait_cnt;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_timeout_cnt_nxt = r_timeout_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                // ready rises on the first edge after reset release
                w_cmd_ready_nxt = 1'b1;
                // accept only against the registered ready the source saw
                if (bus.cmd_valid_i && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_cyc_nxt       = 1'b1;
                    w_we_nxt        = bus.cmd_we_i;
                    w_adr_nxt       = bus.cmd_adr_i;
                    w_dat_nxt       = bus.cmd_dat_i;
                    w_sel_nxt       = bus.cmd_sel_i;
`ifdef WBM_TIMEOUT_EN
                    w_wait_cnt_nxt  = '0;
`endif
                    w_state_nxt     = S_BUS;
                end
            end

            S_BUS: begin
                // ack is tested first so it wins over a coinciding timeout
                if (bus.wbm_ack_i) begin
                    w_cyc_nxt         = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_dat_nxt     = r_we ? '0 : bus.wbm_dat_i;
`ifdef WBM_TIMEOUT_EN
                    w_rsp_timeout_nxt = 1'b0;
`endif
                    w_state_nxt       = S_RESP;
                end
`ifdef WBM_TIMEOUT_EN
                else if (r_wait_cnt == LP_WAIT_LAST) begin
                    w_cyc_nxt         = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_dat_nxt     = '0;
                    w_rsp_timeout_nxt = 1'b1;
                    if (r_timeout_cnt != 8'hFF) begin
                        w_timeout_cnt_nxt = r_timeout_cnt + 8'd1;
                    end
                    w_state_nxt       = S_RESP;
                end else begin
                    w_wait_cnt_nxt    = r_wait_cnt + 8'd1;
                end
`endif
            end

            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    w_rsp_valid_nxt   = 1'b0;
`ifdef WBM_TIMEOUT_EN
                    w_rsp_timeout_nxt = 1'b0;
`endif
                    w_cmd_ready_nxt   = 1'b1;
                    w_state_nxt       = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready_o   = r_cmd_ready;
    assign bus.rsp_valid_o   = r_rsp_valid;
    assign bus.rsp_dat_o     = r_rsp_dat;
    assign bus.wbm_cyc_o     = r_cyc;
    assign bus.wbm_stb_o     = r_cyc;
    assign bus.wbm_we_o      = r_we;
    assign bus.wbm_adr_o     = r_adr;
    assign bus.wbm_dat_o     = r_dat;
    assign bus.wbm_sel_o     = r_sel;
`ifdef WBM_TIMEOUT_EN
    assign bus.rsp_timeout_o = r_rsp_timeout;
    assign bus.timeout_cnt_o = r_timeout_cnt;
`else
    assign bus.rsp_timeout_o = 1'b0;
    assign bus.timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: a vector table of single transactions
// against a programmable Wishbone slave, plus hand-written sequences for
// reset, back-pressure, stray acks, reset during BUS and timeout saturation.
// Runs in both builds; timeout expectations follow WBM_TIMEOUT_EN.
module tb_wb_cmd_master;

    logic clk;
    logic rst_n;

    wb_cmd_master_if u_if ();

    wb_cmd_master #(
        .TIMEOUT(4)
    ) u_dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // programmable slave: acks after slv_delay wait cycles when enabled
    logic        slv_en;
    logic        slv_force_ack;
    int unsigned slv_delay;
    int unsigned slv_cnt;

    always @(posedge clk) begin
        if (!u_if.wbm_cyc_o) slv_cnt <= 0;
        else                 slv_cnt <= slv_cnt + 1;
    end

    assign u_if.wbm_ack_i = slv_force_ack |
                            (u_if.wbm_stb_o & slv_en & (slv_cnt == slv_delay));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One command through the block. Sampling is #1 after each rising edge.
    // seq_ok covers the cycle-accurate handshake: stb the cycle after accept,
    // rsp_valid the cycle cyc drops, cmd_ready the cycle after rsp_ready.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel,
                          output logic [31:0] rdat, output logic to, output int cycles,
                          output logic bus_ok, output logic seq_ok);
        int w;
        bus_ok = 1'b1;
        seq_ok = 1'b1;
        cycles = 0;
        u_if.cmd_we_i    = we;
        u_if.cmd_adr_i   = adr;
        u_if.cmd_dat_i   = dat;
        u_if.cmd_sel_i   = sel;
        u_if.cmd_valid_i = 1'b1;
        w = 0;
        while (!u_if.cmd_ready_o && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!u_if.cmd_ready_o) seq_ok = 1'b0;
        @(posedge clk); #1;
        u_if.cmd_valid_i = 1'b0;
        if (!u_if.wbm_cyc_o) seq_ok = 1'b0;
        while (u_if.wbm_cyc_o && cycles < 300) begin
            if (u_if.wbm_stb_o !== 1'b1 || u_if.wbm_we_o !== we || u_if.wbm_adr_o !== adr ||
                u_if.wbm_dat_o !== dat || u_if.wbm_sel_o !== sel ||
                u_if.cmd_ready_o !== 1'b0 || u_if.rsp_valid_o !== 1'b0)
                bus_ok = 1'b0;
            cycles++;
            @(posedge clk); #1;
        end
        if (u_if.rsp_valid_o !== 1'b1 || u_if.wbm_stb_o !== 1'b0) seq_ok = 1'b0;
        rdat = u_if.rsp_dat_o;
        to   = u_if.rsp_timeout_o;
        u_if.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        u_if.rsp_ready_i = 1'b0;
        if (u_if.rsp_valid_o !== 1'b0 || u_if.cmd_ready_o !== 1'b1) seq_ok = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        slv_ack;
        int unsigned slv_delay;
        logic [31:0] slv_rdata;
        logic [31:0] exp_rdat;
        logic        exp_to;
        int          exp_cycles;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    logic [31:0] rdat;
    logic        to;
    int          cycles;
    logic        bus_ok;
    logic        seq_ok;
    logic        flag;
    logic [7:0]  exp_tcnt;

    initial begin
        vecs[0] = '{we:1'b1, adr:32'h3000_0004, dat:32'hDEAD_BEEF, sel:4'hF, slv_ack:1'b1,
                    slv_delay:2, slv_rdata:32'hFFFF_FFFF, exp_rdat:32'h0, exp_to:1'b0, exp_cycles:3};
        vecs[1] = '{we:1'b0, adr:32'h3000_0000, dat:32'h0, sel:4'hF, slv_ack:1'b1,
                    slv_delay:0, slv_rdata:32'h1234_5678, exp_rdat:32'h1234_5678, exp_to:1'b0, exp_cycles:1};
        vecs[2] = '{we:1'b0, adr:32'h0000_00FC, dat:32'h0, sel:4'h3, slv_ack:1'b1,
                    slv_delay:1, slv_rdata:32'hA5A5_0F0F, exp_rdat:32'hA5A5_0F0F, exp_to:1'b0, exp_cycles:2};
        vecs[3] = '{we:1'b1, adr:32'hFFFF_FFFC, dat:32'h0000_0001, sel:4'h1, slv_ack:1'b1,
                    slv_delay:0, slv_rdata:32'h7777_7777, exp_rdat:32'h0, exp_to:1'b0, exp_cycles:1};
        // ack on the 4th BUS cycle: coincides with the timeout edge, ack wins
        vecs[4] = '{we:1'b0, adr:32'h3000_0008, dat:32'h0, sel:4'hF, slv_ack:1'b1,
                    slv_delay:3, slv_rdata:32'hCAFE_F00D, exp_rdat:32'hCAFE_F00D, exp_to:1'b0, exp_cycles:4};
`ifdef WBM_TIMEOUT_EN
        vecs[5] = '{we:1'b0, adr:32'h3000_000C, dat:32'h0, sel:4'hF, slv_ack:1'b0,
                    slv_delay:0, slv_rdata:32'h0BAD_CAFE, exp_rdat:32'h0, exp_to:1'b1, exp_cycles:4};
        vecs[6] = '{we:1'b1, adr:32'h3000_0010, dat:32'h1111_2222, sel:4'hC, slv_ack:1'b0,
                    slv_delay:0, slv_rdata:32'h0BAD_CAFE, exp_rdat:32'h0, exp_to:1'b1, exp_cycles:4};
`else
        // no timeout logic: long waits far beyond TIMEOUT complete normally
        vecs[5] = '{we:1'b0, adr:32'h3000_000C, dat:32'h0, sel:4'hF, slv_ack:1'b1,
                    slv_delay:20, slv_rdata:32'h0BAD_CAFE, exp_rdat:32'h0BAD_CAFE, exp_to:1'b0, exp_cycles:21};
        vecs[6] = '{we:1'b1, adr:32'h3000_0010, dat:32'h1111_2222, sel:4'hC, slv_ack:1'b1,
                    slv_delay:5, slv_rdata:32'h0BAD_CAFE, exp_rdat:32'h0, exp_to:1'b0, exp_cycles:6};
`endif

        rst_n            = 1'b0;
        slv_en           = 1'b1;
        slv_force_ack    = 1'b0;
        slv_delay        = 0;
        u_if.wbm_dat_i   = '0;
        u_if.cmd_valid_i = 1'b0;
        u_if.cmd_we_i    = 1'b0;
        u_if.cmd_adr_i   = '0;
        u_if.cmd_dat_i   = '0;
        u_if.cmd_sel_i   = '0;
        u_if.rsp_ready_i = 1'b0;
        exp_tcnt         = '0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'b0, u_if.cmd_ready_o}, 32'd0);
        check("rst_cyc_stb",   {30'b0, u_if.wbm_cyc_o, u_if.wbm_stb_o}, 32'd0);
        check("rst_rsp_valid", {31'b0, u_if.rsp_valid_o}, 32'd0);
        check("rst_rsp_dat",   u_if.rsp_dat_o, 32'd0);
        check("rst_bus_fields", u_if.wbm_adr_o | u_if.wbm_dat_o | {27'b0, u_if.wbm_we_o, u_if.wbm_sel_o}, 32'd0);
        check("rst_timeout",   {23'b0, u_if.rsp_timeout_o, u_if.timeout_cnt_o}, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("rel_ready_pre_edge", {31'b0, u_if.cmd_ready_o}, 32'd0);
        @(posedge clk); #1;
        check("rel_ready_first_edge", {31'b0, u_if.cmd_ready_o}, 32'd1);

        // ---- vector table ----
        for (int i = 0; i < NVEC; i++) begin
            slv_en         = vecs[i].slv_ack;
            slv_delay      = vecs[i].slv_delay;
            u_if.wbm_dat_i = vecs[i].slv_rdata;
            do_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rdat, to, cycles, bus_ok, seq_ok);
            if (vecs[i].exp_to && exp_tcnt != 8'hFF) exp_tcnt = exp_tcnt + 8'd1;
            check($sformatf("v%0d_rsp_dat", i),     rdat, vecs[i].exp_rdat);
            check($sformatf("v%0d_rsp_timeout", i), {31'b0, to}, {31'b0, vecs[i].exp_to});
            check($sformatf("v%0d_cyc_cycles", i),  32'(cycles), 32'(vecs[i].exp_cycles));
            check($sformatf("v%0d_bus_fields", i),  {31'b0, bus_ok}, 32'd1);
            check($sformatf("v%0d_handshake", i),   {31'b0, seq_ok}, 32'd1);
            check($sformatf("v%0d_timeout_cnt", i), {24'b0, u_if.timeout_cnt_o}, {24'b0, exp_tcnt});
        end
        // bus fields retained after the last cycle closed
        check("retain_adr", u_if.wbm_adr_o, 32'h3000_0010);
        check("retain_dat_we_sel", {u_if.wbm_dat_o[27:0], u_if.wbm_we_o, u_if.wbm_sel_o[2:0]},
              {28'h111_2222, 1'b1, 3'b100});

        // ---- stray ack while idle ----
        slv_force_ack = 1'b1;
        flag = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (u_if.rsp_valid_o !== 1'b0 || u_if.wbm_cyc_o !== 1'b0 || u_if.cmd_ready_o !== 1'b1)
                flag = 1'b0;
        end
        slv_force_ack = 1'b0;
        check("idle_ack_ignored", {31'b0, flag}, 32'd1);

        // ---- back-pressure with a second command pending ----
        slv_en           = 1'b1;
        slv_delay        = 0;
        u_if.wbm_dat_i   = 32'h5555_AAAA;
        u_if.cmd_we_i    = 1'b0;
        u_if.cmd_adr_i   = 32'h3000_0020;
        u_if.cmd_sel_i   = 4'hF;
        u_if.cmd_valid_i = 1'b1;
        @(posedge clk); #1;   // accept edge
        check("bp_stb_after_accept", {31'b0, u_if.wbm_stb_o}, 32'd1);
        @(posedge clk); #1;   // ack edge
        check("bp_rsp_valid", {31'b0, u_if.rsp_valid_o}, 32'd1);
        u_if.cmd_adr_i = 32'h3000_0024;
        u_if.wbm_dat_i = 32'hFFFF_0000;
        slv_force_ack  = 1'b1;
        flag = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (u_if.rsp_valid_o !== 1'b1 || u_if.rsp_dat_o !== 32'h5555_AAAA ||
                u_if.wbm_cyc_o !== 1'b0 || u_if.cmd_ready_o !== 1'b0)
                flag = 1'b0;
            @(posedge clk); #1;
        end
        slv_force_ack = 1'b0;
        check("bp_hold_stable", {31'b0, flag}, 32'd1);
        check("bp_rsp_dat", u_if.rsp_dat_o, 32'h5555_AAAA);
        u_if.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        u_if.rsp_ready_i = 1'b0;
        check("bp_ready_back", {30'b0, u_if.cmd_ready_o, u_if.rsp_valid_o}, 32'd2);
        @(posedge clk); #1;   // pending command accepted now
        u_if.cmd_valid_i = 1'b0;
        check("bp_second_cyc", {31'b0, u_if.wbm_cyc_o}, 32'd1);
        check("bp_second_adr", u_if.wbm_adr_o, 32'h3000_0024);
        @(posedge clk); #1;
        check("bp_second_rsp", u_if.rsp_dat_o, 32'hFFFF_0000);
        u_if.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        u_if.rsp_ready_i = 1'b0;

        // ---- reset pulsed during BUS ----
        slv_en           = 1'b0;
        u_if.cmd_adr_i   = 32'h3000_0040;
        u_if.cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        u_if.cmd_valid_i = 1'b0;
        check("rb_cyc_before", {31'b0, u_if.wbm_cyc_o}, 32'd1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rb_async_drop", {30'b0, u_if.wbm_cyc_o, u_if.wbm_stb_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rb_in_reset", {30'b0, u_if.cmd_ready_o, u_if.rsp_valid_o}, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("rb_ready_pre_edge", {31'b0, u_if.cmd_ready_o}, 32'd0);
        flag = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (u_if.rsp_valid_o !== 1'b0 || u_if.wbm_cyc_o !== 1'b0 || u_if.cmd_ready_o !== 1'b1)
                flag = 1'b0;
        end
        check("rb_no_response", {31'b0, flag}, 32'd1);
        exp_tcnt = '0;
        check("rb_timeout_cnt_clr", {24'b0, u_if.timeout_cnt_o}, {24'b0, exp_tcnt});

`ifdef WBM_TIMEOUT_EN
        // ---- 300 back-to-back timeouts saturate the counter ----
        slv_en = 1'b0;
        flag = 1'b1;
        for (int t = 0; t < 300; t++) begin
            do_txn(1'b0, 32'h3000_0100, 32'h0, 4'hF, rdat, to, cycles, bus_ok, seq_ok);
            if (exp_tcnt != 8'hFF) exp_tcnt = exp_tcnt + 8'd1;
            if (to !== 1'b1 || rdat !== 32'h0 || cycles != 4 || !seq_ok || !bus_ok) flag = 1'b0;
        end
        check("sat_each_timeout", {31'b0, flag}, 32'd1);
        check("sat_timeout_cnt", {24'b0, u_if.timeout_cnt_o}, 32'd255);
        slv_en         = 1'b1;
        slv_delay      = 0;
        u_if.wbm_dat_i = 32'h0F0F_0F0F;
        do_txn(1'b0, 32'h3000_0104, 32'h0, 4'hF, rdat, to, cycles, bus_ok, seq_ok);
        check("sat_normal_rdat", rdat, 32'h0F0F_0F0F);
        check("sat_cnt_held", {24'b0, u_if.timeout_cnt_o}, {24'b0, exp_tcnt});
`else
        // ---- timeout outputs stay tied low after a long wait ----
        slv_en         = 1'b1;
        slv_delay      = 40;
        u_if.wbm_dat_i = 32'h0F0F_0F0F;
        do_txn(1'b0, 32'h3000_0104, 32'h0, 4'hF, rdat, to, cycles, bus_ok, seq_ok);
        check("long_wait_rdat", rdat, 32'h0F0F_0F0F);
        check("long_wait_cycles", 32'(cycles), 32'd41);
        check("long_wait_tied", {23'b0, to, u_if.timeout_cnt_o}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL set the number of cycles in BUS without ack before abort; legal range 1..255.
REQ-002 wb_clk_i  in  1  single clock; all logic SHALL be rising-edge.
REQ-003 wb_rst_ni  in  1  reset; SHALL be asynchronous and active-low.
REQ-004 cmd_valid_i  in  1  command offered.
REQ-005 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-006 cmd_we_i  in  1  1 = write, 0 = read.
REQ-007 cmd_adr_i  in  32  byte address.
REQ-008 cmd_dat_i  in  32  write data.
REQ-009 cmd_sel_i  in  4  byte lane select.
REQ-010 rsp_valid_o  out  1  response available.
REQ-011 rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
REQ-012 rsp_dat_o  out  32  read data; 0 for writes and timeouts.
REQ-013 rsp_timeout_o  out  1  transaction aborted by timeout.
REQ-014 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic master controls.
REQ-015 wbm_adr_o  out  32; wbm_dat_o  out  32; wbm_sel_o  out  4  Wishbone master address, data, and byte select.
REQ-016 wbm_ack_i  in  1; wbm_dat_i  in  32  slave acknowledge and read data.
REQ-017 timeout_cnt_o  out  8  saturating count of timed-out transactions.

Function
REQ-018 The FSM SHALL have states IDLE, BUS, and RESP; all outputs SHALL be registered.
REQ-019 In IDLE, cmd_ready_o SHALL be 1; in BUS and RESP, it SHALL be 0.
REQ-020 On a handshake in IDLE at edge N, the block SHALL latch we/adr/dat/sel and enter BUS; cyc and stb SHALL be high from N+1.
REQ-021 In BUS, wbm_* outputs SHALL hold stable until ack is sampled; cyc and stb SHALL always be equal.
REQ-022 On wbm_ack_i sampled high at edge M in BUS, the block SHALL:
- drop cyc and stb at M+1;
- capture wbm_dat_i into rsp_dat_o on reads, or load 0 on writes;
- set rsp_valid_o=1 and rsp_timeout_o=0 at M+1;
- enter RESP.
REQ-023 Minimum turnaround with a zero-wait slave: accept N, stb N+1, rsp_valid N+2, cmd_ready N+3 when rsp_ready_i=1 at N+2.
REQ-024 In RESP, rsp_valid_o and rsp_dat_o SHALL hold until rsp_ready_i=1; the block SHALL then clear rsp_valid_o and return to IDLE.
REQ-025 wbm_ack_i outside BUS SHALL be ignored.
REQ-026 wbm_we_o/adr/dat/sel SHALL retain their last values when cyc is low.
REQ-027 The wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-028 When the wait counter equals TIMEOUT, the block SHALL:
- drop cyc and stb;
- set rsp_valid_o=1, rsp_timeout_o=1, rsp_dat_o=0;
- increment timeout_cnt_o, saturating at 255 with no wrap;
- enter RESP.
REQ-029 If ack and the timeout coincide on the same edge, ack SHALL win and the response SHALL be normal.
REQ-030 cmd_valid_i asserted outside IDLE SHALL NOT be accepted or lost; it remains pending upstream.

Reset
REQ-031 While wb_rst_ni=0, all outputs SHALL be 0, including cmd_ready_o, and the FSM SHALL be IDLE.
REQ-032 cmd_ready_o SHALL rise on the first edge after reset release.
REQ-033 Reset during BUS SHALL drop cyc and stb immediately and asynchronously, and the in-flight command SHALL be discarded with no response.
REQ-034 timeout_cnt_o SHALL clear only on reset.

Configuration
REQ-035 Macro WBM_TIMEOUT_EN defined: REQ-027..REQ-029 apply.
REQ-036 Macro WBM_TIMEOUT_EN undefined:
- no wait counter is built;
- BUS SHALL wait indefinitely for ack;
- rsp_timeout_o and timeout_cnt_o SHALL be tied 0.

Verification
REQ-037 Write adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks after 2 wait cycles -> bus fields match, cyc high exactly 3 cycles, rsp_dat=0, rsp_timeout=0.
REQ-038 Read adr=0x3000_0000; zero-wait slave returns 0x1234_5678 -> rsp_valid two cycles after accept, rsp_dat=0x1234_5678, cmd_ready back after rsp_ready.
REQ-039 TIMEOUT=4, no ack -> cyc drops after 4 BUS cycles, rsp_timeout=1, rsp_dat=0, timeout_cnt=1; repeat 300 times -> timeout_cnt=255.
REQ-040 TIMEOUT=4, ack on the 4th BUS cycle -> normal response, timeout_cnt unchanged.
REQ-041 rsp_ready held 0 for 10 cycles with cmd_valid high -> rsp_valid and rsp_dat stable, no second bus cycle, cmd_ready=0 throughout.
REQ-042 Reset pulsed during BUS -> cyc/stb low within the same cycle, no response, cmd_ready=1 one edge after release.
